// File: rtl/rx_trainerror_hs.sv
// Responder side of the TRAINERROR sideband handshake: waits for the partner's entry
// request, answers with the entry response and reports completion. Macro TRAINERROR_RX_TIMEOUT_EN adds the WAIT_REQ timeout.
module rx_trainerror_hs #(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_trainerror_en,
    input  logic                    i_falling_edge_busy,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic                    o_trainerror_end_rx,
    output logic                    o_timeout
);

    localparam logic [SB_MSG_WIDTH-1:0] MSG_REQ  = SB_MSG_WIDTH'(15);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_RESP = SB_MSG_WIDTH'(14);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rx_trainerror_hs: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_SEND_RESP,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    timeout_hit;
    logic [SB_MSG_WIDTH-1:0] enc_d;
    logic                    valid_d;
    logic                    end_d;
    logic                    timeout_d;

`ifdef TRAINERROR_RX_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Restarts on every entry into WAIT_REQ and saturates at the last count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (state != ST_WAIT_REQ && state_nxt == ST_WAIT_REQ) begin
            cnt <= '0;
        end else if (state == ST_WAIT_REQ && cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (cnt == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping the enable wins over every other transition, including a busy pulse.
    always_comb begin
        state_nxt = state;
        if (!i_trainerror_en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_decoded_SB_msg == MSG_REQ) state_nxt = ST_SEND_RESP;
                    else                             state_nxt = ST_WAIT_REQ;
                end
                ST_WAIT_REQ: begin
                    if (i_decoded_SB_msg == MSG_REQ) state_nxt = ST_SEND_RESP;
                    else if (timeout_hit)            state_nxt = ST_TIMEOUT;
                end
                ST_SEND_RESP: begin
                    if (i_falling_edge_busy) state_nxt = ST_DONE;
                end
                ST_DONE:    state_nxt = ST_DONE;
                ST_TIMEOUT: state_nxt = ST_TIMEOUT;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        enc_d     = '0;
        valid_d   = 1'b0;
        end_d     = 1'b0;
        timeout_d = 1'b0;
        case (state_nxt)
            ST_SEND_RESP: begin
                enc_d   = MSG_RESP;
                valid_d = 1'b1;
            end
            ST_DONE: begin
                enc_d = MSG_RESP;
                end_d = 1'b1;
            end
            ST_TIMEOUT: timeout_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_encoded_SB_msg_rx <= '0;
            o_valid_rx          <= 1'b0;
            o_trainerror_end_rx <= 1'b0;
        end else begin
            o_encoded_SB_msg_rx <= enc_d;
            o_valid_rx          <= valid_d;
            o_trainerror_end_rx <= end_d;
        end
    end

`ifdef TRAINERROR_RX_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_d;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rx_trainerror_hs.sv
// Directed bench for rx_trainerror_hs; expected values are hand-derived edge by edge.
module tb_rx_trainerror_hs;

    localparam int W = 4;
    localparam int T = 8;
`ifdef TRAINERROR_RX_TIMEOUT_EN
    localparam int REQ_EDGE = 6;
`else
    localparam int REQ_EDGE = 11;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         busy = 1'b0;
    logic [W-1:0] msg_in = '0;
    logic [W-1:0] enc;
    logic         valid;
    logic         done;
    logic         tmo;

    int n_checks = 0;
    int n_errors = 0;

    rx_trainerror_hs #(
        .SB_MSG_WIDTH  (W),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_trainerror_en    (en),
        .i_falling_edge_busy(busy),
        .i_decoded_SB_msg   (msg_in),
        .o_encoded_SB_msg_rx(enc),
        .o_valid_rx         (valid),
        .o_trainerror_end_rx(done),
        .o_timeout          (tmo)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {enc, valid, end, timeout} packed for compact whole-output checks
    function automatic logic [31:0] outs();
        return {25'd0, enc, valid, done, tmo};
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] e, input logic v, input logic d, input logic t);
        return {25'd0, e, v, d, t};
    endfunction

    initial begin
        // Reset and idle
        #12;
        check_eq("reset_outs", outs(), pack(4'd0, 0, 0, 0));
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("idle_hold", outs(), pack(4'd0, 0, 0, 0));
        end

        // REQ already present when enable rises; busy pulse sampled at edge 6
        msg_in = 4'd15;
        en     = 1'b1;
        tick();
        check_eq("req_edge1", outs(), pack(4'd14, 1, 0, 0));
        for (int i = 2; i <= 5; i++) tick();
        check_eq("req_edge5", outs(), pack(4'd14, 1, 0, 0));
        busy = 1'b1;
        tick();
        busy = 1'b0;
        check_eq("req_done", outs(), pack(4'd14, 0, 1, 0));
        tick(); tick(); tick();
        check_eq("done_held", outs(), pack(4'd14, 0, 1, 0));
        busy = 1'b1;
        tick();
        busy = 1'b0;
        check_eq("busy_in_done", outs(), pack(4'd14, 0, 1, 0));
        en     = 1'b0;
        msg_in = 4'd0;
        tick();
        check_eq("done_to_idle", outs(), pack(4'd0, 0, 0, 0));

        // Enable without REQ, busy in WAIT_REQ, REQ arrives later
        en = 1'b1;
        for (int e = 1; e < REQ_EDGE; e++) begin
            busy = (e == 3);
            tick();
        end
        busy = 1'b0;
        check_eq("wait_no_valid", outs(), pack(4'd0, 0, 0, 0));
        msg_in = 4'd15;
        tick();
        check_eq("late_req_valid", outs(), pack(4'd14, 1, 0, 0));
        tick(); tick(); tick();
        check_eq("late_req_hold", outs(), pack(4'd14, 1, 0, 0));
        busy = 1'b1;
        tick();
        busy = 1'b0;
        check_eq("late_req_done", outs(), pack(4'd14, 0, 1, 0));
        en     = 1'b0;
        msg_in = 4'd0;
        tick();
        check_eq("late_to_idle", outs(), pack(4'd0, 0, 0, 0));

`ifdef TRAINERROR_RX_TIMEOUT_EN
        // Timeout rises exactly at edge T+1
        en = 1'b1;
        for (int e = 1; e <= T; e++) tick();
        check_eq("tmo_not_yet", outs(), pack(4'd0, 0, 0, 0));
        tick();
        check_eq("tmo_edge9", outs(), pack(4'd0, 0, 0, 1));
        msg_in = 4'd15;
        tick(); tick();
        check_eq("tmo_held_ignores_req", outs(), pack(4'd0, 0, 0, 1));
        en     = 1'b0;
        msg_in = 4'd0;
        tick();
        check_eq("tmo_clear", outs(), pack(4'd0, 0, 0, 0));

        // REQ on the very cycle the counter reaches its last value wins
        en = 1'b1;
        for (int e = 1; e <= T; e++) tick();
        msg_in = 4'd15;
        tick();
        check_eq("req_beats_tmo", outs(), pack(4'd14, 1, 0, 0));
        en     = 1'b0;
        msg_in = 4'd0;
        tick();
        check_eq("req_beats_tmo_idle", outs(), pack(4'd0, 0, 0, 0));
`else
        en = 1'b1;
        for (int e = 1; e <= 3 * T; e++) tick();
        check_eq("no_tmo_build", outs(), pack(4'd0, 0, 0, 0));
        en = 1'b0;
        tick();
        check_eq("no_tmo_idle", outs(), pack(4'd0, 0, 0, 0));
`endif

        // Enable drop coincident with busy in SEND_RESP
        msg_in = 4'd15;
        en     = 1'b1;
        tick();
        check_eq("drop_pre", outs(), pack(4'd14, 1, 0, 0));
        en   = 1'b0;
        busy = 1'b1;
        tick();
        busy = 1'b0;
        check_eq("drop_with_busy", outs(), pack(4'd0, 0, 0, 0));
        tick();
        check_eq("drop_stays_idle", outs(), pack(4'd0, 0, 0, 0));

        // Asynchronous reset in SEND_RESP
        en = 1'b1;
        tick();
        check_eq("arst_pre", outs(), pack(4'd14, 1, 0, 0));
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_immediate", outs(), pack(4'd0, 0, 0, 0));
        en     = 1'b0;
        msg_in = 4'd0;
        #1 rst_n = 1'b1;
        tick();
        check_eq("arst_after", outs(), pack(4'd0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_trainerror_hs.md
# rx_trainerror_hs

Responder half of the TRAINERROR sideband handshake inside the LTSM. While the LTSM holds the TRAINERROR enable, this block waits for the partner's TRAINERROR entry request, which the sideband decoder presents as a decoded message code. It then drives the entry response to the sideband encoder using the shared valid/busy handshake, and signals completion to the LTSM. It runs beside the TX-side requester: its `o_valid_rx` is the RX-valid that the requester samples to decide which falling-busy edge belongs to whom.

## Interface
Parameters:
- `SB_MSG_WIDTH`, 4 — width of decoded/encoded sideband message codes.
- `TIMEOUT_CYCLES`, 1000 — cycles allowed in WAIT_REQ before timeout. Used only with `TRAINERROR_RX_TIMEOUT_EN`; must be ≥ 2.

Ports:
- `i_clk`  in  1 — block clock; all state on rising edge.
- `i_rst_n`  in  1 — reset; one clock domain, asynchronous, active-low.
- `i_trainerror_en`  in  1 — LTSM enable; low forces return to IDLE.
- `i_falling_edge_busy`  in  1 — one-cycle pulse from the sideband: current transmit has finished.
- `i_decoded_SB_msg`  in  `SB_MSG_WIDTH` — last decoded partner message; level, held until the next message.
- `o_encoded_SB_msg_rx`  out  `SB_MSG_WIDTH` — message code to encode and send.
- `o_valid_rx`  out  1 — request the sideband to send `o_encoded_SB_msg_rx`.
- `o_trainerror_end_rx`  out  1 — responder handshake complete; held while enabled.
- `o_timeout`  out  1 — partner request not received in time; held while enabled.

## Operation
- Message codes: REQ = 15 (TRAINERROR entry req), RESP = 14 (TRAINERROR entry resp).
- States: IDLE, WAIT_REQ, SEND_RESP, DONE, TIMEOUT. Reset state is IDLE.
- IDLE:
  - en=1 and msg==REQ → SEND_RESP.
  - en=1 and msg≠REQ → WAIT_REQ.
  - Otherwise stay in IDLE.
- WAIT_REQ:
  - msg==REQ → SEND_RESP.
  - Timeout counter reached `TIMEOUT_CYCLES-1` (macro on) → TIMEOUT.
  - Otherwise stay in WAIT_REQ.
  - REQ takes priority over timeout in the same cycle.
- SEND_RESP: `i_falling_edge_busy` → DONE; otherwise stay.
- DONE, TIMEOUT: stay until en=0.
- Any state with en=0 → IDLE on the next edge. This has priority over every other transition, including a coincident busy pulse.
- Output rules:
  - `o_encoded_SB_msg_rx` loads RESP on the edge entering SEND_RESP. It holds RESP through SEND_RESP and DONE.
  - `o_valid_rx` is set on the edge entering SEND_RESP. It is cleared on the edge where `i_falling_edge_busy` is seen in SEND_RESP. A busy pulse outside SEND_RESP is ignored.
  - `o_trainerror_end_rx` is set on the edge entering DONE.
  - `o_timeout` is set on the edge entering TIMEOUT.
- In IDLE, all outputs are registered to 0.
- The timeout counter is `$clog2(TIMEOUT_CYCLES)` bits. It clears to 0 on entering WAIT_REQ and increments each cycle in WAIT_REQ. It saturates and never wraps.

## Timing
- Reset values: `o_encoded_SB_msg_rx`=0, `o_valid_rx`=0, `o_trainerror_end_rx`=0, `o_timeout`=0; state IDLE; counter 0.
- All outputs are registered. Each output changes on the same edge on which the state register takes its new state.
- Edge count is measured from the edge that first samples en=1 with REQ already present:
  - `o_valid_rx` is high after that first edge.
  - The earliest DONE is one edge after a busy pulse sampled in SEND_RESP.
- Timeout (macro on): with en=1 and no REQ, `o_timeout` rises exactly `TIMEOUT_CYCLES+1` edges after the first edge that samples en=1.
- en falls mid-SEND_RESP: `o_valid_rx` and the message return to 0 on the next edge. No DONE occurs.

## Configuration
- `TRAINERROR_RX_TIMEOUT_EN` defined:
  - The counter and TIMEOUT state are compiled in.
  - `o_timeout` behaves as specified above.
- Not defined:
  - No counter is built and TIMEOUT is unreachable.
  - WAIT_REQ waits indefinitely.
  - `o_timeout` is tied to 0.

## Test plan
- Reset with en=0 and msg=0 → all outputs 0; state stays IDLE for 20 cycles.
- en=1 with msg=15 already present, busy pulse 5 cycles later → `o_valid_rx`=1 and `o_encoded_SB_msg_rx`=14 after edge 1. Valid returns to 0 one edge after the pulse. `o_trainerror_end_rx`=1 on the same edge and held.
- en=1 with msg=0, msg=15 at cycle 10, busy at cycle 14 → valid rises at edge 11 and falls at edge 15. End=1 at edge 15.
- Macro on, `TIMEOUT_CYCLES`=8, en=1, no REQ → `o_timeout`=1 at edge 9; valid stays 0. Dropping en clears `o_timeout` on the next edge.
- In SEND_RESP, drop en in the same cycle as a busy pulse → next edge: IDLE, valid=0, msg=0, end=0.
- Busy pulses in WAIT_REQ and DONE → no output change. Asserting `i_rst_n`=0 mid-SEND_RESP → outputs 0 immediately, without waiting for a clock edge.
